// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Frame bits that follow the start bit: data, optional parity, stop bits.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser for the asynchronous rx pin plus falling-edge detect.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic [2:0] ff;
    logic [2:0] primed;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ff     <= '1;
            primed <= '0;
        end else begin
            ff     <= {ff[1:0], rx};
            primed <= {primed[1:0], 1'b1};
        end
    end

    // The all-ones reset value would otherwise look like a line that just fell
    // when rx is held low through reset; wait until ff[2] holds a real sample.
    assign rx_sync = ff[1];
    assign rx_fall = primed[2] & ff[2] & ~ff[1];

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: majority-vote sampling, parity/framing flags,
// valid/ready output register with overrun pulse.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLOCK_BAUD_RATIO = 400,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int R  = CLOCK_BAUD_RATIO;
    localparam int H  = R / 2;
    localparam int K  = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam int CW = $clog2(R);
    localparam int BW = $clog2(K + 1);

    rx_state_e            state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic                 rx_sync, rx_fall;
    logic                 s_early, s_mid, bit_val;
    logic                 at_decide, commit;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, stop_err;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_sync (rx_sync),
        .rx_fall (rx_fall)
    );

    assign at_decide = (cnt == CW'(H + 1));
    assign bit_val   = (s_early & s_mid) | (s_early & rx_sync) | (s_mid & rx_sync);

    // NOTE: state and all registers update with non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        unique case (state)
            ST_IDLE:   if (rx_fall) state_nxt = ST_START;
            ST_START:  if (at_decide) state_nxt = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:   if (at_decide && bit_idx == BW'(DATA_BITS))
                           state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (at_decide) state_nxt = ST_STOP;
            ST_STOP:   if (at_decide && bit_idx == BW'(K)) begin
                           state_nxt = ST_IDLE;
                           commit    = 1'b1;
                       end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // The detect cycle itself counts as cnt = 0, so the counter leaves IDLE at 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            s_early <= 1'b0;
            s_mid   <= 1'b0;
        end else if (state == ST_IDLE) begin
            cnt     <= rx_fall ? CW'(1) : '0;
            bit_idx <= '0;
        end else begin
            if (cnt == CW'(R - 1)) begin
                cnt     <= '0;
                bit_idx <= bit_idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == CW'(H - 1)) s_early <= rx_sync;
            if (cnt == CW'(H))     s_mid   <= rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg      <= '0;
            par_bit    <= 1'b0;
            stop_err   <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (state == ST_IDLE) stop_err <= 1'b0;
            if (at_decide) begin
                if (state == ST_DATA)   shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                if (state == ST_PARITY) par_bit <= bit_val;
                if (state == ST_STOP && !bit_val) stop_err <= 1'b1;
            end
            if (valid && ready) valid <= 1'b0;
            // A held, unaccepted word wins over the new frame.
            if (commit) begin
                if (valid && !ready) begin
                    overrun <= 1'b1;
                end else begin
                    data       <= shreg;
                    parity_err <= (PARITY != PARITY_NONE) &&
                                  ((^shreg ^ par_bit) != (PARITY == PARITY_ODD));
                    frame_err  <= stop_err | ~bit_val;
                    valid      <= 1'b1;
                end
            end
        end
    end

endmodule
